// File: rtl/inst_mem_loader_pkg.sv
// Shared definitions for the instruction-memory loader: FSM encoding,
// default halt marker and the address-width helper.
package inst_mem_loader_pkg;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_RECV  = 2'd1;
   localparam logic [1:0] ST_WRITE = 2'd2;
   localparam logic [1:0] ST_DONE  = 2'd3;

   typedef enum logic [1:0] {
      IDLE  = ST_IDLE,
      RECV  = ST_RECV,
      WRITE = ST_WRITE,
      DONE  = ST_DONE
   } state_e;

   localparam logic [31:0] HALT_WORD_DEFAULT = 32'hFFFF_FFFF;

   // Address bits needed to index n words (at least one bit).
   function automatic int addr_bits(input int n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/inst_mem_loader_byte_assembler.sv
// Four-lane byte register that assembles UART bytes into a word.
// word_o already includes the byte being written this cycle, so the
// controller can capture a complete word on the edge that takes the
// last byte.
module byte_assembler #(
   parameter int NBYTE  = 8,
   parameter int NLANES = 4
) (
   input  logic                       clock_i,
   input  logic                       reset_i,
   input  logic                       clear_i,
   input  logic                       wr_en_i,
   input  logic [$clog2(NLANES)-1:0]  lane_i,
   input  logic [NBYTE-1:0]           byte_i,
   output logic [NLANES*NBYTE-1:0]    word_o
);

   logic [NLANES-1:0][NBYTE-1:0] lanes_q, lanes_d;

   // Merge the incoming byte into its lane.
   always_comb begin
      lanes_d = lanes_q;
      if (wr_en_i) lanes_d[lane_i] = byte_i;
   end

   // Lane storage; clear wins over a simultaneous write.
   always_ff @(posedge clock_i or posedge reset_i) begin
      if (reset_i)      lanes_q <= '0;
      else if (clear_i) lanes_q <= '0;
      else              lanes_q <= lanes_d;
   end

   assign word_o = lanes_d;

endmodule

// File: rtl/inst_mem_loader.sv
// Program loader: assembles little-endian words from the UART byte
// stream, writes them to instruction memory from address 0, stops on
// the halt word or a full memory, and gates fetch until the load is done.
module inst_mem_loader
   import inst_mem_loader_pkg::*;
#(
   parameter int                 NB_DATA    = 32,
   parameter int                 NBYTE      = 8,
   parameter int                 N_ELEMENTS = 128,
   parameter int                 NB_ADDR    = addr_bits(N_ELEMENTS),
   parameter logic [NB_DATA-1:0] HALT_WORD  = NB_DATA'(HALT_WORD_DEFAULT)
) (
   input  logic               clock_i,
   input  logic               reset_i,
   input  logic               start_i,
   input  logic               rx_done_i,
   input  logic [NBYTE-1:0]   rx_data_i,
   input  logic               fetch_en_i,
   output logic               mem_en_write_o,
   output logic [NB_ADDR-1:0] mem_addr_write_o,
   output logic [NB_DATA-1:0] mem_data_o,
   output logic               mem_en_read_o,
   output logic               load_busy_o,
   output logic               load_done_o,
   output logic               overflow_o,
   output logic [NB_ADDR:0]   word_count_o
);

   localparam int NLANES = NB_DATA / NBYTE;
   localparam int BC_W   = $clog2(NLANES);
   localparam logic [BC_W-1:0]  LAST_LANE = BC_W'(NLANES - 1);
   localparam logic [NB_ADDR:0] FULL_CNT  = (NB_ADDR + 1)'(N_ELEMENTS);

   state_e             state_q;
   logic [BC_W-1:0]    byte_cnt_q;
   logic [NB_ADDR:0]   word_cnt_q;
   logic               wr_en_q;
   logic [NB_ADDR-1:0] addr_q;
   logic [NB_DATA-1:0] data_q;
   logic               busy_q, done_q, ovf_q;

   logic [NB_ADDR:0]   word_cnt_d;
   logic [NB_DATA-1:0] asm_word;
   logic               is_halt, is_full, write_last, asm_we;

   assign word_cnt_d = word_cnt_q + 1'b1;
   assign is_halt    = (data_q == HALT_WORD);
   assign is_full    = (word_cnt_d == FULL_CNT);
   assign write_last = is_halt | is_full;

   // A byte is kept in RECV, and in a WRITE that returns to RECV; start drops it.
   assign asm_we = rx_done_i & ~start_i &
                   ((state_q == RECV) | ((state_q == WRITE) & ~write_last));

   byte_assembler #(
      .NBYTE  (NBYTE),
      .NLANES (NLANES)
   ) u_asm (
      .clock_i (clock_i),
      .reset_i (reset_i),
      .clear_i (start_i),
      .wr_en_i (asm_we),
      .lane_i  (byte_cnt_q),
      .byte_i  (rx_data_i),
      .word_o  (asm_word)
   );

   // Load controller: state, counters and registered memory/status outputs.
   always_ff @(posedge clock_i or posedge reset_i) begin
      if (reset_i) begin
         state_q    <= IDLE;
         byte_cnt_q <= '0;
         word_cnt_q <= '0;
         wr_en_q    <= 1'b0;
         addr_q     <= '0;
         data_q     <= '0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         ovf_q      <= 1'b0;
      end else begin
         wr_en_q <= 1'b0;
         if (start_i) begin
            // Begin or restart; a write already on the bus still completes.
            state_q    <= RECV;
            byte_cnt_q <= '0;
            word_cnt_q <= '0;
            ovf_q      <= 1'b0;
            busy_q     <= 1'b1;
            done_q     <= 1'b0;
         end else begin
            case (state_q)
               RECV: begin
                  if (rx_done_i) begin
                     byte_cnt_q <= byte_cnt_q + 1'b1;
                     if (byte_cnt_q == LAST_LANE) begin
                        state_q <= WRITE;
                        wr_en_q <= 1'b1;
                        addr_q  <= word_cnt_q[NB_ADDR-1:0];
                        data_q  <= asm_word;
                     end
                  end
               end
               WRITE: begin
                  word_cnt_q <= word_cnt_d;
                  if (write_last) begin
                     state_q <= DONE;
                     busy_q  <= 1'b0;
                     done_q  <= 1'b1;
                     ovf_q   <= ~is_halt;
                  end else begin
                     state_q    <= RECV;
                     byte_cnt_q <= rx_done_i ? BC_W'(1) : '0;
                  end
               end
               IDLE, DONE: ;
               default: state_q <= IDLE;
            endcase
         end
      end
   end

   assign mem_en_write_o   = wr_en_q;
   assign mem_addr_write_o = addr_q;
   assign mem_data_o       = data_q;
   assign load_busy_o      = busy_q;
   assign load_done_o      = done_q;
   assign overflow_o       = ovf_q;
   assign word_count_o     = word_cnt_q;
   assign mem_en_read_o    = fetch_en_i & done_q;

endmodule

// File: doc/inst_mem_loader.md
# inst_mem_loader

Program loader and port controller for the 128 × 32-bit instruction memory. It takes the UART byte stream, assembles the bytes little-endian into 32-bit words, and issues one write per word at consecutive addresses from 0. Loading stops on a halt word or when memory is full. Until a load completes, the block holds off instruction fetch so the processor never reads a partially loaded program.

## Interface
Parameters:
- NB_DATA, 32, instruction word width
- NBYTE, 8, UART byte width
- N_ELEMENTS, 128, memory depth in words
- NB_ADDR, 7, memory address width (log2 N_ELEMENTS)
- HALT_WORD, 32'hFFFF_FFFF, end-of-program marker

Ports:
- clock_i  in  1  single clock; all state updates on the rising edge
- reset_i  in  1  asynchronous, active-high reset
- start_i  in  1  one-cycle pulse that begins or restarts a load
- rx_done_i  in  1  one-cycle strobe: rx_data_i is valid
- rx_data_i  in  NBYTE  received byte
- fetch_en_i  in  1  processor requests an instruction read
- mem_en_write_o  out  1  write strobe to instruction memory
- mem_addr_write_o  out  NB_ADDR  write address
- mem_data_o  out  NB_DATA  write data
- mem_en_read_o  out  1  gated read enable, equal to fetch_en_i & load_done_o (combinational)
- load_busy_o  out  1  high in RECV or WRITE state
- load_done_o  out  1  high in DONE state
- overflow_o  out  1  load ended because memory filled without a halt word
- word_count_o  out  NB_ADDR+1  number of words written in the current load (0..N_ELEMENTS)

## Operation
- FSM states: IDLE, RECV, WRITE, DONE.
- **Reset:**
  - State goes to IDLE.
  - Every registered output, the byte counter, the word counter and the assembly register clear to 0.
  - mem_en_read_o therefore reads 0.
- **IDLE:** rx_done_i is ignored. start_i moves the FSM to RECV and clears byte_cnt, word_count_o and overflow_o.
- **RECV:**
  - Each rx_done_i stores rx_data_i into byte lane byte_cnt (lane 0 = bits [7:0]) and increments byte_cnt (2 bits, wraps).
  - The byte that brings byte_cnt from 3 to 0 moves the FSM to WRITE.
- **WRITE:** lasts exactly one cycle.
  - Drives mem_en_write_o=1, mem_addr_write_o=word_count_o[NB_ADDR-1:0], mem_data_o=assembled word.
  - word_count_o increments.
  - Next state:
    - DONE if the word equals HALT_WORD. The halt word is written and counted.
    - DONE with overflow_o=1 if the incremented count equals N_ELEMENTS.
    - Otherwise RECV.
- **rx_done_i during WRITE:** the byte is stored in lane 0 and byte_cnt becomes 1, unless WRITE exits to DONE; then the byte is dropped.
- **DONE:**
  - load_done_o=1; fetch is enabled.
  - rx_done_i is ignored; word_count_o and overflow_o hold.
  - start_i returns the FSM to RECV and clears the counters and overflow_o. Memory contents are not cleared.
- **start_i in RECV or WRITE:** aborts the current load.
  - The FSM goes to RECV and counters clear.
  - A partial word is discarded.
  - A write scheduled in that same cycle still completes.
- **start_i together with rx_done_i:** start_i wins and the byte is dropped.

## Timing
- Write latency: mem_en_write_o asserts in the cycle after the edge that samples the 4th rx_done_i. It is a single-cycle pulse.
- mem_addr_write_o and mem_data_o are registered and stable while mem_en_write_o=1. They hold their last values otherwise.
- load_done_o rises in the cycle after the WRITE that ends the load.
- mem_en_read_o is combinational from fetch_en_i and load_done_o (no added latency). Memory read data follows one cycle later, per the memory's registered read port.
- Maximum rx_done_i rate is one per cycle with no byte loss, except the drop cases listed above.
- Reset mid-load: all outputs drop asynchronously. A write pulse asserted at reset is cut short.

## Structure
- Shared package contains:
  - FSM state encoding (2-bit localparams)
  - HALT_WORD default
  - NB_ADDR derivation helper (clog2 of N_ELEMENTS)
- One sub-module, byte_assembler: 4-lane register, lane select by byte_cnt, clear input. The FSM and counters live in inst_mem_loader.

## Test plan
- **Reset values:** reset_i=1 mid-load, with fetch_en_i=1 → all outputs 0, mem_en_read_o=0, state IDLE.
- **Normal load:** start_i, then bytes 0x11,0x22,0x33,0x44, then 0xFF×4 → write addr 0 data 0x44332211; write addr 1 data 0xFFFFFFFF; load_done_o=1; word_count_o=2; overflow_o=0.
- **Fetch gating:** fetch_en_i=1 throughout a load → mem_en_read_o=0 until the cycle load_done_o=1, then 1.
- **Overflow:** 128 non-halt words, e.g. 0x00000000 → 128 writes at addr 0..127; load_done_o=1; overflow_o=1; word_count_o=128; a 129th byte is ignored.
- **Abort:** start_i after 2 bytes of word 1 → no write for the partial word; next 4 bytes 0xAA,0xBB,0xCC,0xDD write 0xDDCCBBAA to addr 0.
- **Back-to-back bytes:** rx_done_i every cycle, including the WRITE cycle → no byte lost; words land at addr 0,1,2 with correct lane order.
